// File: rtl/sha256_padder.sv
// sha256_padder: byte-stream to 512-bit chunk pre-processor for SHA-256.
// Appends the 0x80 marker, zero fill and 64-bit big-endian bit length, and
// emits chunks over a valid/ready handshake. Byte 0 of a chunk is chunk[511:504].
//
// Ports
//   clock, reset       : clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready : message byte stream (in_last marks final byte)
//   chunk/chunk_valid/chunk_ready     : padded 512-bit block handshake
//   chunk_first/chunk_last            : block is first / final block of its message
module sha256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] chunk,
  output logic         chunk_valid,
  input  logic         chunk_ready,
  output logic         chunk_first,
  output logic         chunk_last
);

  localparam int unsigned CHUNK_W = 512;
  localparam int unsigned NBYTES  = CHUNK_W / 8;

  typedef enum logic [1:0] {ST_FILL, ST_EMIT, ST_XTRA} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LEN, PEND_MARK_LEN} pend_t;

  state_t             state_q, state_d;
  pend_t              pend_q, pend_d;
  logic [CHUNK_W-1:0] buf_q, buf_d;
  logic [5:0]         p_q, p_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               first_pend_q, first_pend_d;
  logic               chunk_first_q, chunk_first_d;
  logic               chunk_last_q, chunk_last_d;
  logic               chunk_valid_q, chunk_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [6:0]         q;
  logic [LEN_W-1:0]   len_inc;

  assign chunk       = buf_q;
  assign chunk_valid = chunk_valid_q;
  assign chunk_first = chunk_first_q;
  assign chunk_last  = chunk_last_q;
  assign in_ready    = in_ready_q;

  // Next-state, buffer update and registered-output decode
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    buf_d         = buf_q;
    p_d           = p_q;
    len_d         = len_q;
    first_pend_d  = first_pend_q;
    chunk_first_d = chunk_first_q;
    chunk_last_d  = chunk_last_q;
    q             = {1'b0, p_q} + 7'd1;
    len_inc       = len_q + LEN_W'(8);

    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          len_d = len_inc;
          for (int i = 0; i < int'(NBYTES); i++) begin
            if (6'(i) == p_q) buf_d[CHUNK_W-1-8*i -: 8] = in_data;
          end
          if (in_last) begin
            state_d       = ST_EMIT;
            chunk_first_d = first_pend_q;
            // Bytes beyond p are already zero since the buffer is cleared per chunk
            for (int i = 0; i < int'(NBYTES); i++) begin
              if (7'(i) == q) buf_d[CHUNK_W-1-8*i -: 8] = 8'h80;
            end
            if (q <= 7'd55) begin
              buf_d[63:0]  = 64'(len_inc);
              chunk_last_d = 1'b1;
            end else if (q == 7'd64) begin
              pend_d       = PEND_MARK_LEN;
              chunk_last_d = 1'b0;
            end else begin
              pend_d       = PEND_LEN;
              chunk_last_d = 1'b0;
            end
          end else if (p_q == 6'd63) begin
            state_d       = ST_EMIT;
            chunk_first_d = first_pend_q;
            chunk_last_d  = 1'b0;
          end else begin
            p_d = p_q + 6'd1;
          end
        end
      end

      ST_EMIT: begin
        if (chunk_ready) begin
          // first_pend re-arms only after the final block of a message
          first_pend_d = chunk_last_q;
          if (pend_q != PEND_NONE) begin
            state_d = ST_XTRA;
          end else begin
            state_d       = ST_FILL;
            buf_d         = '0;
            p_d           = '0;
            chunk_first_d = 1'b0;
            chunk_last_d  = 1'b0;
            if (chunk_last_q) len_d = '0;
          end
        end
      end

      ST_XTRA: begin
        // Extra block: optional marker at byte 0, length in the tail
        buf_d = '0;
        if (pend_q == PEND_MARK_LEN) buf_d[CHUNK_W-1 -: 8] = 8'h80;
        buf_d[63:0]   = 64'(len_q);
        chunk_first_d = first_pend_q;
        chunk_last_d  = 1'b1;
        pend_d        = PEND_NONE;
        state_d       = ST_EMIT;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    chunk_valid_d = (state_d == ST_EMIT);
    in_ready_d    = (state_d == ST_FILL);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FILL;
      pend_q        <= PEND_NONE;
      buf_q         <= '0;
      p_q           <= '0;
      len_q         <= '0;
      first_pend_q  <= 1'b1;
      chunk_first_q <= 1'b0;
      chunk_last_q  <= 1'b0;
      chunk_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      buf_q         <= buf_d;
      p_q           <= p_d;
      len_q         <= len_d;
      first_pend_q  <= first_pend_d;
      chunk_first_q <= chunk_first_d;
      chunk_last_q  <= chunk_last_d;
      chunk_valid_q <= chunk_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: directed test-plan messages plus randomized
// messages, checked against a queue-based padding reference model.
module tb_sha256_padder;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [511:0] chunk;
  logic         chunk_valid;
  logic         chunk_ready = 1'b0;
  logic         chunk_first;
  logic         chunk_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  sha256_padder #(.LEN_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: message + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit count
  task automatic build_expected();
    logic [7:0]   pad[$];
    logic [63:0]  bitlen;
    logic [511:0] c;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
    exp_q.delete();
    for (int b = 0; b < pad.size() / 64; b++) begin
      c = '0;
      for (int j = 0; j < 64; j++) c[511-8*j -: 8] = pad[64*b+j];
      exp_q.push_back(c);
    end
  endtask

  task automatic do_reset();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    chunk_ready = 1'b0;
    reset       = 1'b0;
    #1;
    check("rst_valid", 512'(chunk_valid), 512'(0));
    check("rst_first", 512'(chunk_first), 512'(0));
    check("rst_last",  512'(chunk_last),  512'(0));
    check("rst_chunk", chunk, 512'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 512'(in_ready), 512'(1));
    check("rel_valid", 512'(chunk_valid), 512'(0));
  endtask

  // Drive msg_q through the DUT and check every chunk it produces.
  // rmode: 0 always ready, 1 random ready, 2 ready low for 5 valid cycles.
  task automatic run_msg(input bit gaps, input int rmode);
    int n;
    int nch;
    bit extra;
    n = msg_q.size();
    build_expected();
    nch = exp_q.size();
    extra = (n % 64 >= 56) || (n % 64 == 0);
    fork
      begin
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
          @(negedge clock);
          cyc++;
          if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
          end else begin
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = (i == n - 1);
            if (in_ready) i++;
          end
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i != n) check("drv_timeout", 512'(i), 512'(n));
        else check("valid_after_last", 512'(chunk_valid), 512'(1));
      end
      begin
        int c = 0;
        int cyc = 0;
        int wcnt = 0;
        int bub = 0;
        logic [511:0] held = '0;
        logic hf = 1'b0;
        logic hl = 1'b0;
        while (c < nch && cyc < 2000) begin
          @(negedge clock);
          cyc++;
          if (bub == 1) begin
            check("bubble", 512'(chunk_valid), 512'(0));
            bub = 2;
          end else if (bub == 2) begin
            check("extra_valid", 512'(chunk_valid), 512'(1));
            bub = 0;
          end
          if (chunk_valid) begin
            check("in_ready_emit", 512'(in_ready), 512'(0));
            if (wcnt == 0) begin
              held = chunk;
              hf   = chunk_first;
              hl   = chunk_last;
            end else begin
              check("hold_chunk", chunk, held);
              check("hold_first", 512'(chunk_first), 512'(hf));
              check("hold_last",  512'(chunk_last),  512'(hl));
            end
            case (rmode)
              0:       chunk_ready = 1'b1;
              1:       chunk_ready = 1'($urandom_range(0, 1));
              default: chunk_ready = (wcnt >= 5);
            endcase
            wcnt++;
            if (chunk_ready) begin
              check("chunk", chunk, exp_q[c]);
              check("first", 512'(chunk_first), 512'(c == 0));
              check("last",  512'(chunk_last),  512'(c == nch - 1));
              if (extra && c == nch - 2) bub = 1;
              c++;
              wcnt = 0;
            end
          end else begin
            chunk_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end
        @(negedge clock);
        chunk_ready = 1'b0;
        if (c != nch) check("col_timeout", 512'(c), 512'(nch));
      end
    join
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  initial begin
    int lens[11] = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 128};

    do_reset();

    load_abc();
    run_msg(1'b0, 0);

    msg_q.delete();
    for (int k = 0; k < 55; k++) msg_q.push_back(8'h00);
    run_msg(1'b0, 0);

    msg_q.delete();
    for (int k = 0; k < 56; k++) msg_q.push_back(8'h41);
    run_msg(1'b0, 0);

    msg_q.delete();
    for (int k = 0; k < 80; k++) msg_q.push_back(8'(k));
    run_msg(1'b0, 0);
    load_abc();
    run_msg(1'b0, 0);

    msg_q.delete();
    for (int k = 0; k < 64; k++) msg_q.push_back(8'hFF);
    run_msg(1'b0, 2);

    // Reset mid-message
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    do_reset();
    load_abc();
    run_msg(1'b0, 0);

    // Reset while a full chunk is waiting
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_valid", 512'(chunk_valid), 512'(1));
    do_reset();
    load_abc();
    run_msg(1'b1, 1);

    foreach (lens[k]) begin
      msg_q.delete();
      for (int j = 0; j < lens[k]; j++) msg_q.push_back(8'($urandom));
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    for (int r = 0; r < 25; r++) begin
      int len;
      len = int'($urandom_range(1, 200));
      msg_q.delete();
      for (int j = 0; j < len; j++) msg_q.push_back(8'($urandom));
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
